// File: rtl/jkl_bank.sv
// jkl_bank: WIDTH-bit bank of JK flops with JK, count-up, count-down and shift modes.
// Define JKL_BANK_LOAD_EN to add a parallel load port that overrides enable and mode.
module jkl_bank #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             e,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qnot,
  output logic             changed,
  output logic             tc
`ifdef JKL_BANK_LOAD_EN
  ,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value
`endif
);

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_UP    = 2'b01,
    MODE_DOWN  = 2'b10,
    MODE_SHIFT = 2'b11
  } mode_t;

  logic [WIDTH-1:0] up_toggle;
  logic [WIDTH-1:0] down_toggle;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] j_eff;
  logic [WIDTH-1:0] k_eff;
  logic [WIDTH-1:0] q_next;
  logic             ones_run;
  logic             zeros_run;

  // Ripple-free toggle masks: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up_toggle   = '0;
    down_toggle = '0;
    ones_run    = 1'b1;
    zeros_run   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_toggle[i]   = ones_run;
      down_toggle[i] = zeros_run;
      ones_run       = ones_run & q[i];
      zeros_run      = zeros_run & ~q[i];
    end
  end

  assign shifted = {q[WIDTH-2:0], ser_in};

  // Every mode is expressed as per-bit J/K drives into the same JK characteristic.
  always_comb begin
    j_eff = j;
    k_eff = k;
    case (mode_t'(mode))
      MODE_UP: begin
        j_eff = up_toggle;
        k_eff = up_toggle;
      end
      MODE_DOWN: begin
        j_eff = down_toggle;
        k_eff = down_toggle;
      end
      MODE_SHIFT: begin
        j_eff = shifted;
        k_eff = ~shifted;
      end
      default: begin
        j_eff = j;
        k_eff = k;
      end
    endcase
    q_next = (j_eff & ~q) | (~k_eff & q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q       <= RESET_VALUE;
      qnot    <= ~RESET_VALUE;
      changed <= 1'b0;
    end
`ifdef JKL_BANK_LOAD_EN
    else if (load) begin
      q       <= load_value;
      qnot    <= ~load_value;
      changed <= (load_value != q);
    end
`endif
    else if (e) begin
      q       <= q_next;
      qnot    <= ~q_next;
      changed <= (q_next != q);
    end else begin
      changed <= 1'b0;
    end
  end

  assign tc = ((mode_t'(mode) == MODE_UP) && (&q)) ||
              ((mode_t'(mode) == MODE_DOWN) && (q == '0));

endmodule

// File: tb/tb_jkl_bank.sv
// tb_jkl_bank: scoreboard bench for jkl_bank (WIDTH=8, RESET_VALUE=8'hA5).
// Define JKL_BANK_LOAD_EN to also exercise the parallel load port.
module tb_jkl_bank;

  localparam logic [7:0] RV = 8'hA5;

  typedef struct {
    logic [7:0] q;
    logic       ch;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       e = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] j = '0;
  logic [7:0] k = '0;
  logic       ser_in = 1'b0;
  logic [7:0] q;
  logic [7:0] qnot;
  logic       changed;
  logic       tc;
`ifdef JKL_BANK_LOAD_EN
  logic       load = 1'b0;
  logic [7:0] load_value = '0;
`endif

  exp_t       sb[$];
  exp_t       got;
  logic [7:0] mq;
  int         total = 0;
  int         bad = 0;

  jkl_bank #(.WIDTH(8), .RESET_VALUE(RV)) dut (
    .clock(clock), .reset(reset), .e(e), .mode(mode), .j(j), .k(k),
    .ser_in(ser_in), .q(q), .qnot(qnot), .changed(changed), .tc(tc)
`ifdef JKL_BANK_LOAD_EN
    , .load(load), .load_value(load_value)
`endif
  );

  always #5 clock = ~clock;

  // Drive one edge worth of inputs, push the model's prediction, and land #1 after the edge.
  task automatic applyStimulus(input logic r, input logic en, input logic [1:0] m,
                               input logic [7:0] jj, input logic [7:0] kk, input logic si,
                               input logic ld, input logic [7:0] lv);
    exp_t nx;
    reset = r; e = en; mode = m; j = jj; k = kk; ser_in = si;
`ifdef JKL_BANK_LOAD_EN
    load = ld; load_value = lv;
`endif
    if (r) begin
      nx.q = RV; nx.ch = 1'b0;
    end else if (ld) begin
      nx.q = lv; nx.ch = (lv != mq);
    end else if (!en) begin
      nx.q = mq; nx.ch = 1'b0;
    end else begin
      case (m)
        2'b00:   nx.q = (mq & ~jj & ~kk) | (jj & ~kk) | (jj & kk & ~mq);
        2'b01:   nx.q = mq + 8'd1;
        2'b10:   nx.q = mq - 8'd1;
        default: nx.q = {mq[6:0], si};
      endcase
      nx.ch = (nx.q != mq);
    end
    sb.push_back(nx);
    @(posedge clock);
    #1;
    mq = nx.q;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    got = sb.pop_front();
    total++;
    if ({q, qnot, changed} !== {got.q, ~got.q, got.ch} || q !== 8'hA5) begin
      bad++;
      $display("[TB] FAIL reset: got q=%h qnot=%h changed=%b, want q=%h qnot=%h changed=%b",
               q, qnot, changed, got.q, ~got.q, got.ch);
    end
  endtask

  task automatic test_jk();
    logic [7:0] jt[5] = '{8'h00, 8'hF0, 8'hFF, 8'h00, 8'h3C};
    logic [7:0] kt[5] = '{8'hFF, 8'h0F, 8'hFF, 8'h00, 8'hC3};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 2'b00, jt[i], kt[i], 1'b0, 1'b0, 8'h00);
      got = sb.pop_front();
      total++;
      if ({q, qnot, changed} !== {got.q, ~got.q, got.ch}) begin
        bad++;
        $display("[TB] FAIL jk[%0d]: got q=%h qnot=%h changed=%b, want q=%h qnot=%h changed=%b",
                 i, q, qnot, changed, got.q, ~got.q, got.ch);
      end
    end
  endtask

  task automatic test_count_up();
    logic [1:0] mt[6]  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    logic       et[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       tct[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      mode = mt[i];
      #1;
      total++;
      if (tc !== tct[i]) begin
        bad++;
        $display("[TB] FAIL up_tc[%0d]: got tc=%b, want tc=%b (q=%h)", i, tc, tct[i], q);
      end
      applyStimulus(1'b0, et[i], mt[i], 8'hFE, 8'h01, 1'b0, 1'b0, 8'h00);
      got = sb.pop_front();
      total++;
      if ({q, qnot, changed} !== {got.q, ~got.q, got.ch}) begin
        bad++;
        $display("[TB] FAIL up[%0d]: got q=%h qnot=%h changed=%b, want q=%h qnot=%h changed=%b",
                 i, q, qnot, changed, got.q, ~got.q, got.ch);
      end
    end
  endtask

  task automatic test_count_down();
    logic [1:0] mt[4]  = '{2'b00, 2'b10, 2'b10, 2'b10};
    logic       et[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       tct[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      mode = mt[i];
      #1;
      total++;
      if (tc !== tct[i]) begin
        bad++;
        $display("[TB] FAIL down_tc[%0d]: got tc=%b, want tc=%b (q=%h)", i, tc, tct[i], q);
      end
      applyStimulus(1'b0, et[i], mt[i], 8'h01, 8'hFE, 1'b0, 1'b0, 8'h00);
      got = sb.pop_front();
      total++;
      if ({q, qnot, changed} !== {got.q, ~got.q, got.ch}) begin
        bad++;
        $display("[TB] FAIL down[%0d]: got q=%h qnot=%h changed=%b, want q=%h qnot=%h changed=%b",
                 i, q, qnot, changed, got.q, ~got.q, got.ch);
      end
    end
  endtask

  task automatic test_shift();
    logic [1:0] mt[7] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    logic       st[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       rt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(rt[i], 1'b1, mt[i], 8'h00, 8'hFF, st[i], 1'b0, 8'h00);
      got = sb.pop_front();
      total++;
      if ({q, qnot, changed} !== {got.q, ~got.q, got.ch}) begin
        bad++;
        $display("[TB] FAIL shift[%0d]: got q=%h qnot=%h changed=%b, want q=%h qnot=%h changed=%b",
                 i, q, qnot, changed, got.q, ~got.q, got.ch);
      end
    end
    total++;
    if (q !== 8'hA5) begin
      bad++;
      $display("[TB] FAIL shift_reset: got q=%h, want q=a5", q);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] m;
    logic       en;
    logic       exp_tc;
    for (int i = 0; i < 40; i++) begin
      m  = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 4) != 0);
      mode = m;
      e = en;
      #1;
      exp_tc = (m == 2'b01 && mq == 8'hFF) || (m == 2'b10 && mq == 8'h00);
      total++;
      if (tc !== exp_tc) begin
        bad++;
        $display("[TB] FAIL b2b_tc[%0d]: got tc=%b, want tc=%b (q=%h mode=%0d)", i, tc, exp_tc, q, m);
      end
      applyStimulus(1'b0, en, m, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 8'h00);
      got = sb.pop_front();
      total++;
      if ({q, qnot, changed} !== {got.q, ~got.q, got.ch}) begin
        bad++;
        $display("[TB] FAIL b2b[%0d]: got q=%h qnot=%h changed=%b, want q=%h qnot=%h changed=%b",
                 i, q, qnot, changed, got.q, ~got.q, got.ch);
      end
    end
  endtask

`ifdef JKL_BANK_LOAD_EN
  task automatic test_load();
    logic       rt[3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] lt[3] = '{8'h3C, 8'h3C, 8'h77};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(rt[i], 1'b0, 2'b01, 8'h00, 8'h00, 1'b0, 1'b1, lt[i]);
      got = sb.pop_front();
      total++;
      if ({q, qnot, changed} !== {got.q, ~got.q, got.ch}) begin
        bad++;
        $display("[TB] FAIL load[%0d]: got q=%h qnot=%h changed=%b, want q=%h qnot=%h changed=%b",
                 i, q, qnot, changed, got.q, ~got.q, got.ch);
      end
    end
    load = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    mq = 'x;
    test_reset();
    test_jk();
    test_count_up();
    test_count_down();
    test_shift();
    test_back_to_back();
`ifdef JKL_BANK_LOAD_EN
    test_load();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
